// File: rtl/key_frame_transmitter.sv
// Serial sender for the access-key frame: KEY_WIDTH secret bits (LSB first) then one MODE bit.
// Latency: first frame bit appears on the cycle after Start is sampled; all outputs registered.
// No backpressure: Start is honoured only in IDLE, never queued; Abort cuts a frame short.
//
// Ports:
//   Clk, Reset         rising-edge clock, asynchronous active-high reset
//   Start, ModeReq     frame request and the MODE bit captured with it
//   Abort              cancel the frame in progress (SEND only)
//   ValidCmd, InputKey serial frame strobe and data bit (InputKey=0 when ValidCmd=0)
//   Busy, Done         high in SEND/GAP; one-cycle pulse after a completed frame
module key_frame_transmitter #(
  parameter int                    KEY_WIDTH  = 4,
  parameter logic [KEY_WIDTH-1:0]  SECRET     = 4'b0101,
  parameter int                    GAP_CYCLES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  input  logic ModeReq,
  input  logic Abort,
  output logic ValidCmd,
  output logic InputKey,
  output logic Busy,
  output logic Done
);

  localparam int CW = $clog2(KEY_WIDTH + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(KEY_WIDTH);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
  logic            mode, mode_nxt;
  logic            valid_nxt, key_nxt, busy_nxt, done_nxt;
  logic [CW-1:0]   bit_inc;
  logic            secret_bit;

  assign bit_inc = bit_cnt + 1'b1;

  // Secret bit for the next frame position; bit_inc can reach LAST_BIT, which is
  // beyond the secret and is served by the captured mode instead.
  always_comb begin
    secret_bit = 1'b0;
    for (int k = 0; k < KEY_WIDTH; k++) begin
      if (bit_inc == CW'(k)) secret_bit = SECRET[k];
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    mode_nxt    = mode;
    valid_nxt   = 1'b0;
    key_nxt     = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        // Start beats a simultaneous Abort here: Abort only matters in SEND.
        if (Start) begin
          state_nxt   = SEND;
          bit_cnt_nxt = '0;
          mode_nxt    = ModeReq;
          valid_nxt   = 1'b1;
          key_nxt     = SECRET[0];
          busy_nxt    = 1'b1;
        end
      end
      SEND: begin
        busy_nxt = 1'b1;
        if (Abort || bit_cnt == LAST_BIT) begin
          // Abort wins over the last-bit edge, so Done only follows a full frame.
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
          done_nxt    = !Abort;
        end else begin
          bit_cnt_nxt = bit_inc;
          valid_nxt   = 1'b1;
          key_nxt     = (bit_inc == LAST_BIT) ? mode : secret_bit;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
          busy_nxt    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      mode     <= 1'b0;
      ValidCmd <= 1'b0;
      InputKey <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      mode     <= mode_nxt;
      ValidCmd <= valid_nxt;
      InputKey <= key_nxt;
      Busy     <= busy_nxt;
      Done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_key_frame_transmitter.sv
// Bench for key_frame_transmitter: a timeline model schedules the expected outputs of each
// accepted frame edge by edge; one compare process checks them every cycle, plus literal
// waveform tables for a few directed frames.
module tb_key_frame_transmitter;

  localparam int KW  = 4;
  localparam int GAP = 2;
  localparam int N   = 8192;
  localparam logic [KW-1:0] SECRET = 4'b0101;

  logic Clk, Reset, Start, ModeReq, Abort;
  logic ValidCmd, InputKey, Busy, Done;
  logic rst_probe = 1'b0;

  key_frame_transmitter #(.KEY_WIDTH(KW), .SECRET(SECRET), .GAP_CYCLES(GAP)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ModeReq(ModeReq), .Abort(Abort),
    .ValidCmd(ValidCmd), .InputKey(InputKey), .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected outputs after edge number e.
  bit ev [N];
  bit ek [N];
  bit ed [N];
  bit eb [N];
  int edge_n = 0;
  int idle_edge = 1;
  int fs = -100;
  int checks = 0;
  int errors = 0;
  int pin_tab = 0;
  int pin_e0 = 0;

  // Timeline model.
  always begin
    @(posedge Clk or posedge Reset);
    if (Reset) begin
      for (int i = 0; i <= 40; i++) begin
        if (edge_n + i < N) begin
          ev[edge_n+i] = 0; ek[edge_n+i] = 0; ed[edge_n+i] = 0; eb[edge_n+i] = 0;
        end
      end
      idle_edge = edge_n + 1;
      fs = -100;
    end else begin
      edge_n++;
      if (edge_n >= idle_edge && Start === 1'b1) begin
        fs = edge_n;
        for (int k = 0; k <= KW; k++) begin
          if (fs + k < N) begin
            ev[fs+k] = 1;
            ek[fs+k] = (k < KW) ? SECRET[k] : ModeReq;
          end
        end
        for (int k = 0; k <= KW + GAP; k++) if (fs + k < N) eb[fs+k] = 1;
        if (fs + KW + 1 < N) ed[fs+KW+1] = 1;
        idle_edge = fs + KW + 1 + GAP + 1;
      end else if (edge_n > fs && edge_n <= fs + KW + 1 && Abort === 1'b1) begin
        for (int k = 0; k <= KW + GAP + 1; k++) begin
          if (edge_n + k < N) begin
            ev[edge_n+k] = 0; ek[edge_n+k] = 0; ed[edge_n+k] = 0; eb[edge_n+k] = 0;
          end
        end
        for (int k = 0; k < GAP; k++) if (edge_n + k < N) eb[edge_n+k] = 1;
        idle_edge = edge_n + GAP + 1;
        fs = -100;
      end
    end
  end

  task automatic chk(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge %0d got %b want %b", nm, edge_n, act, req);
    end
  endtask

  // Literal waveforms, bit d = cycle d+1 after the accepting edge.
  localparam logic [7:0] VAL_FULL  = 8'b00011111;
  localparam logic [7:0] KEY_M0    = 8'b00000101;
  localparam logic [7:0] KEY_M1    = 8'b00010101;
  localparam logic [7:0] DONE_FULL = 8'b00100000;
  localparam logic [7:0] BUSY_FULL = 8'b01111111;
  localparam logic [7:0] VAL_ABT   = 8'b00000111;
  localparam logic [7:0] BUSY_ABT  = 8'b00011111;

  always begin
    @(negedge Clk or posedge rst_probe);
    if (rst_probe || Reset) begin
      chk("rst_valid", ValidCmd, 1'b0);
      chk("rst_key",   InputKey, 1'b0);
      chk("rst_busy",  Busy,     1'b0);
      chk("rst_done",  Done,     1'b0);
    end else begin
      chk("valid", ValidCmd, ev[edge_n]);
      chk("key",   InputKey, ek[edge_n]);
      chk("busy",  Busy,     eb[edge_n]);
      chk("done",  Done,     ed[edge_n]);
      if (pin_tab != 0 && edge_n - pin_e0 >= 0 && edge_n - pin_e0 < 8) begin
        int d;
        d = edge_n - pin_e0;
        case (pin_tab)
          1: begin
            chk("pin_valid_m0", ValidCmd, VAL_FULL[d]);
            chk("pin_key_m0",   InputKey, KEY_M0[d]);
            chk("pin_done_m0",  Done,     DONE_FULL[d]);
            chk("pin_busy_m0",  Busy,     BUSY_FULL[d]);
          end
          2: begin
            chk("pin_valid_m1", ValidCmd, VAL_FULL[d]);
            chk("pin_key_m1",   InputKey, KEY_M1[d]);
            chk("pin_done_m1",  Done,     DONE_FULL[d]);
            chk("pin_busy_m1",  Busy,     BUSY_FULL[d]);
          end
          default: begin
            chk("pin_valid_abort", ValidCmd, VAL_ABT[d]);
            chk("pin_key_abort",   InputKey, KEY_M0[d] & VAL_ABT[d]);
            chk("pin_done_abort",  Done,     1'b0);
            chk("pin_busy_abort",  Busy,     BUSY_ABT[d]);
          end
        endcase
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic frame(input logic mode, input int tab);
    ModeReq = mode;
    Start = 1'b1;
    step(1);
    Start = 1'b0;
    pin_e0 = edge_n;
    pin_tab = tab;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; ModeReq = 1'b0; Abort = 1'b0;
    step(3);
    Reset = 1'b0;
    step(10);

    // Plain frame, mode 0.
    frame(1'b0, 1);
    step(10);
    pin_tab = 0;

    // Mode 1 with ModeReq wiggling mid-frame.
    frame(1'b1, 2);
    step(2); ModeReq = 1'b0;
    step(2); ModeReq = 1'b1;
    step(8);
    pin_tab = 0;

    // Start pulses inside the frame and inside the gap are dropped.
    frame(1'b0, 1);
    step(2); Start = 1'b1;
    step(1); Start = 1'b0;
    step(3); Start = 1'b1;
    step(1); Start = 1'b0;
    step(5);
    pin_tab = 0;

    // Abort while bit 2 is on the line, then a fresh frame right after the gap.
    frame(1'b0, 3);
    step(2); Abort = 1'b1;
    step(1); Abort = 1'b0;
    step(3);
    frame(1'b1, 2);
    step(10);
    pin_tab = 0;

    // Reset while bit 3 is on the line, then restart.
    frame(1'b1, 0);
    step(3);
    Reset = 1'b1;
    #1 rst_probe = 1'b1;
    #1 rst_probe = 1'b0;
    step(1);
    Reset = 1'b0;
    step(2);
    frame(1'b0, 1);
    step(10);
    pin_tab = 0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      Start   = ($urandom_range(0, 99) < 25);
      Abort   = ($urandom_range(0, 99) < 8);
      ModeReq = $urandom_range(0, 1) == 1;
      if (Reset) Reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) Reset = 1'b1;
      step(1);
    end
    Start = 1'b0; Abort = 1'b0; Reset = 1'b0;
    step(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
